// File: rtl/axi_stream_packet_arbiter_if.sv
// Stream bundle between NB_SRC AXI-Stream sources and the single shared output.
// Ports: s_axis_* per-source request side (packed vectors, source i in lane i), m_axis_* shared output side.
// master modport: the arbiter's view (drives m_axis_* and s_axis_tready); slave modport: the environment's view.
interface axi_stream_packet_arbiter_if #(
   parameter int NB_SRC = 4,
   parameter int WIDTH  = 32
);
   localparam int ID_W = $clog2(NB_SRC);

   logic [NB_SRC-1:0]       s_axis_tvalid;
   logic [NB_SRC-1:0]       s_axis_tready;
   logic [NB_SRC*WIDTH-1:0] s_axis_tdata;
   logic [NB_SRC-1:0]       s_axis_tlast;

   logic                    m_axis_tvalid;
   logic                    m_axis_tready;
   logic [WIDTH-1:0]        m_axis_tdata;
   logic [WIDTH/8-1:0]      m_axis_tstrb;
   logic                    m_axis_tlast;
   logic [ID_W-1:0]         m_axis_tid;

   modport master (
      input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
      output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tstrb, m_axis_tlast, m_axis_tid
   );

   modport slave (
      output s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
      input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tstrb, m_axis_tlast, m_axis_tid
   );
endinterface

// File: rtl/axi_stream_packet_arbiter.sv
// Purpose: packet-granular round-robin arbiter sharing one AXI-Stream output among NB_SRC sources.
// Latency: 1 IDLE arbitration cycle per packet, then 1 registered beat/cycle; one bubble between packets.
// Backpressure: granted source sees tready = output slot free; all m_axis_* held while tvalid & !tready.
// Ports: m_axis_clk, rst_n (async, active-low), axis (master modport of the stream bundle),
//        busy (high while streaming a packet), grant_id (current or last granted source).
module axi_stream_packet_arbiter #(
   parameter int NB_SRC = 4,
   parameter int WIDTH  = 32
) (
   input  logic                      m_axis_clk,
   input  logic                      rst_n,
   axi_stream_packet_arbiter_if.master axis,
   output logic                      busy,
   output logic [$clog2(NB_SRC)-1:0] grant_id
);
   localparam int ID_W  = $clog2(NB_SRC);
   localparam int SUM_W = ID_W + 1;
   localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NB_SRC - 1);
   localparam logic [ID_W-1:0]  ONE_ID  = ID_W'(1);
   localparam logic [SUM_W-1:0] NB_SUM  = SUM_W'(NB_SRC);

   typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

   state_t           state, state_nxt;
   logic [ID_W-1:0]  rr_ptr, rr_ptr_nxt, grant_nxt;
   logic [ID_W-1:0]  pick_id;
   logic             pick_vld;
   logic [SUM_W-1:0] scan_idx;
   logic             slot_free;
   logic             beat_acc;
   logic             grant_vld;
   logic             grant_last;
   logic [WIDTH-1:0] grant_dat;

   assign slot_free  = ~axis.m_axis_tvalid | axis.m_axis_tready;
   assign grant_vld  = axis.s_axis_tvalid[grant_id];
   assign grant_last = axis.s_axis_tlast[grant_id];
   assign grant_dat  = axis.s_axis_tdata[grant_id*WIDTH +: WIDTH];
   // Same condition that raises s_axis_tready[grant_id], so this is exactly the source handshake.
   assign beat_acc   = busy & slot_free & grant_vld;

   assign axis.m_axis_tstrb = '1;

   // Scan requesters starting at rr_ptr; the index is formed one bit wider and folded back
   // so non-power-of-two NB_SRC wraps correctly.
   always_comb begin
      pick_id  = '0;
      pick_vld = 1'b0;
      scan_idx = '0;
      for (int k = 0; k < NB_SRC; k++) begin
         scan_idx = {1'b0, rr_ptr} + SUM_W'(k);
         if (scan_idx >= NB_SUM) begin
            scan_idx = scan_idx - NB_SUM;
         end
         if (!pick_vld && axis.s_axis_tvalid[scan_idx[ID_W-1:0]]) begin
            pick_vld = 1'b1;
            pick_id  = scan_idx[ID_W-1:0];
         end
      end
   end

   // State register, including the grant and round-robin pointer that move with it.
   always_ff @(posedge m_axis_clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         grant_id <= '0;
         rr_ptr   <= '0;
      end else begin
         state    <= state_nxt;
         grant_id <= grant_nxt;
         rr_ptr   <= rr_ptr_nxt;
      end
   end

   // Next-state logic. The grant is held until the tlast beat is taken, however long the
   // granted source stalls; there is no timeout or preemption.
   always_comb begin
      state_nxt  = state;
      grant_nxt  = grant_id;
      rr_ptr_nxt = rr_ptr;
      case (state)
         IDLE: begin
            if (pick_vld) begin
               state_nxt = STREAM;
               grant_nxt = pick_id;
            end
         end
         STREAM: begin
            if (beat_acc && grant_last) begin
               state_nxt  = IDLE;
               rr_ptr_nxt = (grant_id == LAST_ID) ? '0 : grant_id + ONE_ID;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic: only the granted lane can see ready, and only while the output slot is free.
   always_comb begin
      busy               = (state == STREAM);
      axis.s_axis_tready = '0;
      if (state == STREAM) begin
         axis.s_axis_tready[grant_id] = slot_free;
      end
   end

   // Single output register; keeps draining in IDLE, holds everything while stalled.
   always_ff @(posedge m_axis_clk or negedge rst_n) begin
      if (!rst_n) begin
         axis.m_axis_tvalid <= 1'b0;
         axis.m_axis_tdata  <= '0;
         axis.m_axis_tlast  <= 1'b0;
         axis.m_axis_tid    <= '0;
      end else if (beat_acc) begin
         axis.m_axis_tvalid <= 1'b1;
         axis.m_axis_tdata  <= grant_dat;
         axis.m_axis_tlast  <= grant_last;
         axis.m_axis_tid    <= grant_id;
      end else if (axis.m_axis_tready) begin
         axis.m_axis_tvalid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_axi_stream_packet_arbiter.sv
// Purpose: self-checking bench for axi_stream_packet_arbiter with a packet-level round-robin model.
// Latency: inputs driven on the falling edge, outputs sampled 1 time unit later.
// Backpressure: m_axis_tready driven constant, 1-0-0 pattern, or random depending on the test.
module tb_axi_stream_packet_arbiter;
   localparam int NB  = 4;
   localparam int W   = 32;
   localparam int IDW = 2;

   typedef struct {
      int             cyc;
      logic [IDW-1:0] tid;
      logic           last;
      logic [W-1:0]   dat;
   } beat_t;

   logic           m_axis_clk = 1'b0;
   logic           rst_n;
   logic           busy;
   logic [IDW-1:0] grant_id;

   axi_stream_packet_arbiter_if #(.NB_SRC(NB), .WIDTH(W)) bus ();

   axi_stream_packet_arbiter #(.NB_SRC(NB), .WIDTH(W)) dut (
      .m_axis_clk (m_axis_clk),
      .rst_n      (rst_n),
      .axis       (bus.master),
      .busy       (busy),
      .grant_id   (grant_id)
   );

   always #5 m_axis_clk = ~m_axis_clk;

   // Per-source beat queues: {tlast, tdata}.
   logic [W:0]       src_q [NB][$];
   logic [NB-1:0]    hold;
   logic [NB-1:0]    first_pend;
   logic             rand_gap;
   int               rdy_mode;
   beat_t            obs[$];
   beat_t            exp_q[$];
   int               cyc;
   logic             stall_prev;
   logic [W+IDW+1:0] stall_snap;
   int               chk_cnt;
   int               pass_cnt;

   function automatic logic queues_empty();
      for (int i = 0; i < NB; i++) begin
         if (src_q[i].size() != 0) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic push_pkt(input int src, input int len, input logic [W-1:0] base, input logic rnd);
      logic [W-1:0] d;
      for (int j = 0; j < len; j++) begin
         d = rnd ? W'($urandom) : base + W'(j);
         src_q[src].push_back({(j == len - 1), d});
      end
   endtask

   // Reference: whole packets in round-robin order over the sources that still have packets.
   task automatic model_run(input int start_ptr, output int end_ptr);
      logic [W:0] mq [NB][$];
      logic [W:0] e;
      beat_t      b;
      int         ptr;
      int         g;
      for (int i = 0; i < NB; i++) mq[i] = src_q[i];
      ptr = start_ptr;
      forever begin
         g = -1;
         for (int k = 0; k < NB; k++) begin
            if (g < 0 && mq[(ptr + k) % NB].size() > 0) g = (ptr + k) % NB;
         end
         if (g < 0) break;
         do begin
            e      = mq[g].pop_front();
            b.cyc  = 0;
            b.tid  = IDW'(g);
            b.last = e[W];
            b.dat  = e[W-1:0];
            exp_q.push_back(b);
         end while (!e[W] && mq[g].size() > 0);
         ptr = (g + 1) % NB;
      end
      end_ptr = ptr;
   endtask

   // One clock: drive on the falling edge, sample shortly after, record handshakes.
   task automatic cycle();
      logic  gap;
      beat_t b;
      @(negedge m_axis_clk);
      for (int i = 0; i < NB; i++) begin
         gap = hold[i] | (rand_gap & ~first_pend[i] & ($urandom_range(0, 2) == 0));
         if (src_q[i].size() > 0 && !gap) begin
            bus.s_axis_tvalid[i]       = 1'b1;
            bus.s_axis_tdata[i*W +: W] = src_q[i][0][W-1:0];
            bus.s_axis_tlast[i]        = src_q[i][0][W];
         end else begin
            bus.s_axis_tvalid[i]       = 1'b0;
            bus.s_axis_tdata[i*W +: W] = W'($urandom);
            bus.s_axis_tlast[i]        = 1'($urandom_range(0, 1));
         end
      end
      case (rdy_mode)
         1:       bus.m_axis_tready = 1'($urandom_range(0, 1));
         2:       bus.m_axis_tready = (cyc % 3 == 0);
         default: bus.m_axis_tready = 1'b1;
      endcase
      #1;
      if (stall_prev) begin
         chk_cnt++;
         if ({bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tid, bus.m_axis_tdata} !== stall_snap)
            $display("FAIL stall_hold cyc=%0d got %h want %h", cyc,
                     {bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tid, bus.m_axis_tdata}, stall_snap);
         else pass_cnt++;
      end
      chk_cnt++;
      if ($countones(bus.s_axis_tready) > 1 ||
          (bus.m_axis_tvalid && !bus.m_axis_tready && bus.s_axis_tready != '0))
         $display("FAIL s_tready_legal cyc=%0d got %b (m_tvalid=%b m_tready=%b) want onehot0, zero when stalled",
                  cyc, bus.s_axis_tready, bus.m_axis_tvalid, bus.m_axis_tready);
      else pass_cnt++;
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
         b.cyc  = cyc;
         b.tid  = bus.m_axis_tid;
         b.last = bus.m_axis_tlast;
         b.dat  = bus.m_axis_tdata;
         obs.push_back(b);
      end
      for (int i = 0; i < NB; i++) begin
         if (bus.s_axis_tvalid[i] && bus.s_axis_tready[i]) begin
            first_pend[i] = src_q[i][0][W];
            void'(src_q[i].pop_front());
         end
      end
      stall_prev = bus.m_axis_tvalid & ~bus.m_axis_tready;
      stall_snap = {bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tid, bus.m_axis_tdata};
      cyc++;
   endtask

   task automatic drain(input int budget, output logic done);
      done = 1'b0;
      for (int n = 0; n < budget; n++) begin
         cycle();
         if (queues_empty() && !busy && !bus.m_axis_tvalid) begin
            done = 1'b1;
            break;
         end
      end
   endtask

   task automatic clear_bench();
      bus.s_axis_tvalid = '0;
      bus.s_axis_tdata  = '0;
      bus.s_axis_tlast  = '0;
      bus.m_axis_tready = 1'b1;
      for (int i = 0; i < NB; i++) src_q[i].delete();
      obs.delete();
      exp_q.delete();
      hold       = '0;
      first_pend = '1;
      rand_gap   = 1'b0;
      rdy_mode   = 0;
      stall_prev = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge m_axis_clk);
      rst_n = 1'b0;
      clear_bench();
      @(negedge m_axis_clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.s_axis_tvalid = '1;
      bus.s_axis_tlast  = '1;
      bus.s_axis_tdata  = {NB{32'hDEADBEEF}};
      bus.m_axis_tready = 1'b1;
      repeat (2) @(posedge m_axis_clk);
      #1;
      chk_cnt++;
      if ({bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tid} !== '0)
         $display("FAIL reset_m_ctrl got %b want 0", {bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tid});
      else pass_cnt++;
      chk_cnt++;
      if (bus.m_axis_tdata !== '0) $display("FAIL reset_m_tdata got %h want 0", bus.m_axis_tdata);
      else pass_cnt++;
      chk_cnt++;
      if (bus.s_axis_tready !== '0) $display("FAIL reset_s_tready got %b want 0", bus.s_axis_tready);
      else pass_cnt++;
      chk_cnt++;
      if ({busy, grant_id} !== '0) $display("FAIL reset_busy_grant got %b want 0", {busy, grant_id});
      else pass_cnt++;
      chk_cnt++;
      if (bus.m_axis_tstrb !== 4'hF) $display("FAIL reset_tstrb got %h want f", bus.m_axis_tstrb);
      else pass_cnt++;
      clear_bench();
      @(negedge m_axis_clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset_mid_stream();
      logic done;
      int   p;
      apply_reset();
      push_pkt(0, 4, 32'h100, 1'b0);
      for (int n = 0; n < 20 && src_q[0].size() != 1; n++) cycle();
      @(posedge m_axis_clk);
      #2;
      chk_cnt++;
      if (bus.m_axis_tvalid !== 1'b1 || bus.s_axis_tready[0] !== 1'b1)
         $display("FAIL midrst_pre got tvalid=%b tready0=%b want 1 1", bus.m_axis_tvalid, bus.s_axis_tready[0]);
      else pass_cnt++;
      rst_n = 1'b0;
      #1;
      chk_cnt++;
      if (bus.m_axis_tvalid !== 1'b0 || bus.s_axis_tready !== '0 || busy !== 1'b0 || bus.m_axis_tdata !== '0)
         $display("FAIL midrst_async got tvalid=%b tready=%b busy=%b tdata=%h want 0 0 0 0",
                  bus.m_axis_tvalid, bus.s_axis_tready, busy, bus.m_axis_tdata);
      else pass_cnt++;
      clear_bench();
      @(negedge m_axis_clk);
      rst_n = 1'b1;
      push_pkt(2, 2, 32'h200, 1'b0);
      model_run(0, p);
      cycle();
      chk_cnt++;
      if (bus.s_axis_tready !== '0 || busy !== 1'b0)
         $display("FAIL midrst_idle got tready=%b busy=%b want 0 0", bus.s_axis_tready, busy);
      else pass_cnt++;
      cycle();
      chk_cnt++;
      if (bus.s_axis_tready !== 4'b0100 || grant_id !== 2'd2 || busy !== 1'b1)
         $display("FAIL midrst_grant got tready=%b grant=%0d busy=%b want 0100 2 1", bus.s_axis_tready, grant_id, busy);
      else pass_cnt++;
      drain(50, done);
      chk_cnt++;
      if (!done || obs.size() != exp_q.size())
         $display("FAIL midrst_count got %0d beats done=%b want %0d", obs.size(), done, exp_q.size());
      else pass_cnt++;
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
         chk_cnt++;
         if (obs[i].dat !== exp_q[i].dat || obs[i].tid !== exp_q[i].tid || obs[i].last !== exp_q[i].last)
            $display("FAIL midrst_beat%0d got %h/%0d/%b want %h/%0d/%b", i, obs[i].dat, obs[i].tid, obs[i].last,
                     exp_q[i].dat, exp_q[i].tid, exp_q[i].last);
         else pass_cnt++;
      end
   endtask

   task automatic test_single_source();
      logic done;
      int   p;
      int   cyc0;
      apply_reset();
      push_pkt(1, 3, 32'hA0, 1'b0);
      push_pkt(1, 3, 32'hA0, 1'b0);
      model_run(0, p);
      cyc0 = cyc;
      drain(60, done);
      chk_cnt++;
      if (!done || obs.size() != exp_q.size())
         $display("FAIL single_count got %0d beats done=%b want %0d", obs.size(), done, exp_q.size());
      else pass_cnt++;
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
         chk_cnt++;
         if (obs[i].dat !== exp_q[i].dat || obs[i].tid !== 2'd1 || obs[i].last !== (i % 3 == 2))
            $display("FAIL single_beat%0d got %h/%0d/%b want %h/1/%b", i, obs[i].dat, obs[i].tid, obs[i].last,
                     exp_q[i].dat, (i % 3 == 2));
         else pass_cnt++;
      end
      if (obs.size() == 6) begin
         chk_cnt++;
         if (obs[0].cyc !== cyc0 + 2) $display("FAIL single_latency got %0d want %0d", obs[0].cyc, cyc0 + 2);
         else pass_cnt++;
         for (int i = 1; i < 6; i++) begin
            chk_cnt++;
            if (obs[i].cyc - obs[i-1].cyc !== ((i == 3) ? 2 : 1))
               $display("FAIL single_spacing%0d got %0d want %0d", i, obs[i].cyc - obs[i-1].cyc, (i == 3) ? 2 : 1);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_round_robin();
      logic done;
      int   p;
      apply_reset();
      for (int pk = 0; pk < 2; pk++)
         for (int s = 0; s < NB; s++) push_pkt(s, 2, W'(16 * s + 2 * pk), 1'b0);
      model_run(0, p);
      drain(100, done);
      chk_cnt++;
      if (!done || obs.size() != exp_q.size())
         $display("FAIL rr_count got %0d beats done=%b want %0d", obs.size(), done, exp_q.size());
      else pass_cnt++;
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
         chk_cnt++;
         if (obs[i].dat !== exp_q[i].dat || obs[i].tid !== IDW'((i / 2) % NB) || obs[i].last !== exp_q[i].last)
            $display("FAIL rr_beat%0d got %h/%0d/%b want %h/%0d/%b", i, obs[i].dat, obs[i].tid, obs[i].last,
                     exp_q[i].dat, (i / 2) % NB, exp_q[i].last);
         else pass_cnt++;
      end
   endtask

   task automatic test_backpressure();
      logic done;
      apply_reset();
      rdy_mode = 2;
      push_pkt(3, 4, 32'h30, 1'b0);
      done = 1'b0;
      for (int n = 0; n < 100 && !done; n++) begin
         cycle();
         if (busy) begin
            chk_cnt++;
            if (bus.s_axis_tready[3] !== !(bus.m_axis_tvalid && !bus.m_axis_tready))
               $display("FAIL bp_tready3 cyc=%0d got %b want %b", cyc, bus.s_axis_tready[3],
                        !(bus.m_axis_tvalid && !bus.m_axis_tready));
            else pass_cnt++;
         end
         done = queues_empty() && !busy && !bus.m_axis_tvalid;
      end
      chk_cnt++;
      if (!done || obs.size() != 4) $display("FAIL bp_count got %0d beats done=%b want 4", obs.size(), done);
      else pass_cnt++;
      for (int i = 0; i < obs.size() && i < 4; i++) begin
         chk_cnt++;
         if (obs[i].dat !== W'(32'h30 + i) || obs[i].tid !== 2'd3 || obs[i].last !== (i == 3))
            $display("FAIL bp_beat%0d got %h/%0d/%b want %h/3/%b", i, obs[i].dat, obs[i].tid, obs[i].last,
                     32'h30 + i, (i == 3));
         else pass_cnt++;
      end
   endtask

   task automatic test_mid_packet_gap();
      logic done;
      int   p;
      apply_reset();
      push_pkt(0, 3, 32'h50, 1'b0);
      push_pkt(1, 2, 32'h60, 1'b0);
      model_run(0, p);
      for (int n = 0; n < 20 && src_q[0].size() != 2; n++) cycle();
      hold[0] = 1'b1;
      repeat (5) begin
         cycle();
         chk_cnt++;
         if (bus.s_axis_tready[1] !== 1'b0 || grant_id !== 2'd0 || busy !== 1'b1)
            $display("FAIL gap_hold cyc=%0d got tready1=%b grant=%0d busy=%b want 0 0 1",
                     cyc, bus.s_axis_tready[1], grant_id, busy);
         else pass_cnt++;
      end
      hold[0] = 1'b0;
      drain(60, done);
      chk_cnt++;
      if (!done || obs.size() != 5) $display("FAIL gap_count got %0d beats done=%b want 5", obs.size(), done);
      else pass_cnt++;
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
         chk_cnt++;
         if (obs[i].dat !== exp_q[i].dat || obs[i].tid !== ((i < 3) ? 2'd0 : 2'd1) || obs[i].last !== exp_q[i].last)
            $display("FAIL gap_beat%0d got %h/%0d/%b want %h/%0d/%b", i, obs[i].dat, obs[i].tid, obs[i].last,
                     exp_q[i].dat, (i < 3) ? 0 : 1, exp_q[i].last);
         else pass_cnt++;
      end
   endtask

   task automatic test_wrap_tstrb();
      logic done;
      int   p;
      apply_reset();
      push_pkt(2, 1, 32'h77, 1'b0);
      drain(30, done);
      chk_cnt++;
      if (!done || obs.size() != 1 || obs[0].dat !== 32'h77 || obs[0].tid !== 2'd2 || obs[0].last !== 1'b1)
         $display("FAIL wrap_single got n=%0d done=%b want one beat 77/2/1", obs.size(), done);
      else pass_cnt++;
      obs.delete();
      exp_q.delete();
      push_pkt(0, 2, 32'h80, 1'b0);
      push_pkt(3, 2, 32'h90, 1'b0);
      model_run(3, p);
      done = 1'b0;
      for (int n = 0; n < 60 && !done; n++) begin
         cycle();
         chk_cnt++;
         if (bus.m_axis_tstrb !== 4'hF) $display("FAIL wrap_tstrb got %h want f", bus.m_axis_tstrb);
         else pass_cnt++;
         done = queues_empty() && !busy && !bus.m_axis_tvalid;
      end
      chk_cnt++;
      if (!done || obs.size() != 4) $display("FAIL wrap_count got %0d beats done=%b want 4", obs.size(), done);
      else pass_cnt++;
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
         chk_cnt++;
         if (obs[i].dat !== exp_q[i].dat || obs[i].tid !== ((i < 2) ? 2'd3 : 2'd0) || obs[i].last !== exp_q[i].last)
            $display("FAIL wrap_beat%0d got %h/%0d/%b want %h/%0d/%b", i, obs[i].dat, obs[i].tid, obs[i].last,
                     exp_q[i].dat, (i < 2) ? 3 : 0, exp_q[i].last);
         else pass_cnt++;
      end
   endtask

   task automatic test_random();
      logic done;
      int   ptr;
      apply_reset();
      ptr = 0;
      for (int r = 0; r < 4; r++) begin
         obs.delete();
         exp_q.delete();
         rand_gap = 1'b1;
         rdy_mode = 1;
         for (int s = 0; s < NB; s++)
            for (int k = $urandom_range(0, 3); k > 0; k--) push_pkt(s, $urandom_range(1, 4), '0, 1'b1);
         model_run(ptr, ptr);
         drain(3000, done);
         chk_cnt++;
         if (!done || obs.size() != exp_q.size())
            $display("FAIL rand%0d_count got %0d beats done=%b want %0d", r, obs.size(), done, exp_q.size());
         else pass_cnt++;
         for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            chk_cnt++;
            if (obs[i].dat !== exp_q[i].dat || obs[i].tid !== exp_q[i].tid || obs[i].last !== exp_q[i].last)
               $display("FAIL rand%0d_beat%0d got %h/%0d/%b want %h/%0d/%b", r, i, obs[i].dat, obs[i].tid,
                        obs[i].last, exp_q[i].dat, exp_q[i].tid, exp_q[i].last);
            else pass_cnt++;
         end
      end
   endtask

   initial begin
      chk_cnt    = 0;
      pass_cnt   = 0;
      cyc        = 0;
      stall_snap = '0;
      clear_bench();
      test_reset();
      test_reset_mid_stream();
      test_single_source();
      test_round_robin();
      test_backpressure();
      test_mid_packet_gap();
      test_wrap_tstrb();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog got timeout want completion (%0d/%0d so far)", pass_cnt, chk_cnt);
      $fatal(1);
   end
endmodule
